// File: rtl/mips_controller.sv
// Multicycle Moore control unit for the 8-bit MIPS datapath: fetches four instruction
// bytes, decodes op, sequences execute/memory/writeback and decodes the ALU operation.
module mips_controller (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    output logic       o_memread,
    output logic       o_memwrite,
    output logic       o_iord,
    output logic [3:0] o_irwrite,
    output logic       o_regwrite,
    output logic       o_regdst,
    output logic       o_memtoreg,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_pcsrc,
    output logic       o_pcen,
    output logic [2:0] o_alucontrol,
    output logic [3:0] o_state
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,  FETCH2  = 4'd1,  FETCH3 = 4'd2,  FETCH4 = 4'd3,
        DECODE  = 4'd4,  MEMADR  = 4'd5,  LBRD   = 4'd6,  LBWR   = 4'd7,
        SBWR    = 4'd8,  RTYPEEX = 4'd9,  RTYPEWR = 4'd10, BEQEX = 4'd11,
        JEX     = 4'd12, ADDIEX  = 4'd13, ADDIWR = 4'd14
    } state_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic [3:0] irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    // Moore output table; registered alongside the state so outputs track r_state.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                c.memread = 1'b1;
                c.irwrite = 4'b0001 << s[1:0];
                c.alusrcb = 2'b01;
                c.pcwrite = 1'b1;
            end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            LBRD:    begin c.memread = 1'b1; c.iord = 1'b1; end
            LBWR:    begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
            SBWR:    begin c.memwrite = 1'b1; c.iord = 1'b1; end
            RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALU_FUNCT; end
            RTYPEWR: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALU_SUB;
                c.branch  = 1'b1;
                c.pcsrc   = 2'b01;
            end
            JEX:     begin c.pcwrite = 1'b1; c.pcsrc = 2'b10; end
            ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ADDIWR:  c.regwrite = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t      r_state;
    state_t      w_next;
    ctrl_t       r_ctrl;
    logic [2:0]  w_alucontrol;

    always_comb begin
        w_next = FETCH1;
        case (r_state)
            FETCH1: w_next = FETCH2;
            FETCH2: w_next = FETCH3;
            FETCH3: w_next = FETCH4;
            FETCH4: w_next = DECODE;
            DECODE: begin
                case (i_op)
                    OP_LB, OP_SB: w_next = MEMADR;
                    OP_RTYPE:     w_next = RTYPEEX;
                    OP_BEQ:       w_next = BEQEX;
                    OP_J:         w_next = JEX;
                    OP_ADDI:      w_next = ADDIEX;
                    default:      w_next = FETCH1;
                endcase
            end
            MEMADR:  w_next = (i_op == OP_LB) ? LBRD : SBWR;
            LBRD:    w_next = LBWR;
            RTYPEEX: w_next = RTYPEWR;
            ADDIEX:  w_next = ADDIWR;
            default: w_next = FETCH1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= FETCH1;
            r_ctrl  <= decode_ctrl(FETCH1);
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode_ctrl(w_next);
        end
    end

    always_comb begin
        w_alucontrol = 3'b010;
        case (r_ctrl.aluop)
            ALU_SUB: w_alucontrol = 3'b110;
            ALU_FUNCT: begin
                case (i_funct)
                    6'b100010: w_alucontrol = 3'b110;
                    6'b100100: w_alucontrol = 3'b000;
                    6'b100101: w_alucontrol = 3'b001;
                    6'b101010: w_alucontrol = 3'b111;
                    default:   w_alucontrol = 3'b010;
                endcase
            end
            default: w_alucontrol = 3'b010;
        endcase
    end

    // Reset gates every output in the same cycle so an aborted instruction writes nothing.
    assign o_memread    = r_ctrl.memread  & ~i_reset;
    assign o_memwrite   = r_ctrl.memwrite & ~i_reset;
    assign o_iord       = r_ctrl.iord     & ~i_reset;
    assign o_irwrite    = i_reset ? 4'b0000 : r_ctrl.irwrite;
    assign o_regwrite   = r_ctrl.regwrite & ~i_reset;
    assign o_regdst     = r_ctrl.regdst   & ~i_reset;
    assign o_memtoreg   = r_ctrl.memtoreg & ~i_reset;
    assign o_alusrca    = r_ctrl.alusrca  & ~i_reset;
    assign o_alusrcb    = i_reset ? 2'b00 : r_ctrl.alusrcb;
    assign o_pcsrc      = i_reset ? 2'b00 : r_ctrl.pcsrc;
    assign o_pcen       = ~i_reset & (r_ctrl.pcwrite | (r_ctrl.branch & i_zero));
    assign o_alucontrol = i_reset ? 3'b000 : w_alucontrol;
    assign o_state      = i_reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: walks each instruction class and checks state
// sequence and control outputs against hand-computed values.
module tb_mips_controller;
    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memread, memwrite, iord, regwrite, regdst, memtoreg, alusrca, pcen;
    logic [3:0] irwrite;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int checks;
    int failures;

    mips_controller dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_op         (op),
        .i_funct      (funct),
        .i_zero       (zero),
        .o_memread    (memread),
        .o_memwrite   (memwrite),
        .o_iord       (iord),
        .o_irwrite    (irwrite),
        .o_regwrite   (regwrite),
        .o_regdst     (regdst),
        .o_memtoreg   (memtoreg),
        .o_alusrca    (alusrca),
        .o_alusrcb    (alusrcb),
        .o_pcsrc      (pcsrc),
        .o_pcen       (pcen),
        .o_alucontrol (alucontrol),
        .o_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at FETCH1; leaves the bench in the state following DECODE.
    task automatic fetch_decode(input string name);
        for (int n = 0; n < 4; n++) begin
            check({name, " fetch state"}, 8'(state), 8'(n));
            check({name, " fetch irwrite"}, 8'(irwrite), 8'(4'b0001 << n));
            check({name, " fetch pcen"}, 8'(pcen), 8'd1);
            check({name, " fetch memread"}, 8'(memread), 8'd1);
            check({name, " fetch alusrcb"}, 8'(alusrcb), 8'd1);
            step();
        end
        check({name, " decode state"}, 8'(state), 8'd4);
        check({name, " decode alusrcb"}, 8'(alusrcb), 8'd3);
        check({name, " decode pcen"}, 8'(pcen), 8'd0);
        check({name, " decode irwrite"}, 8'(irwrite), 8'd0);
        check({name, " decode memwrite"}, 8'(memwrite), 8'd0);
        check({name, " decode regwrite"}, 8'(regwrite), 8'd0);
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        op       = 6'b000000;
        funct    = 6'b100010;
        zero     = 1'b0;
        @(negedge clk);
        repeat (3) step();
        check("reset state", 8'(state), 8'd0);
        check("reset irwrite", 8'(irwrite), 8'd0);
        check("reset pcen", 8'(pcen), 8'd0);
        check("reset regwrite", 8'(regwrite), 8'd0);
        check("reset memread", 8'(memread), 8'd0);

        // R-type sub
        reset = 1'b0;
        #1;
        fetch_decode("rsub");
        check("rsub ex state", 8'(state), 8'd9);
        check("rsub ex alucontrol", 8'(alucontrol), 8'b110);
        check("rsub ex alusrca", 8'(alusrca), 8'd1);
        check("rsub ex regwrite", 8'(regwrite), 8'd0);
        step();
        check("rsub wr state", 8'(state), 8'd10);
        check("rsub wr regwrite", 8'(regwrite), 8'd1);
        check("rsub wr regdst", 8'(regdst), 8'd1);
        step();
        check("rsub done state", 8'(state), 8'd0);
        check("rsub done regwrite", 8'(regwrite), 8'd0);

        // R-type or, and unknown funct
        funct = 6'b100101;
        fetch_decode("ror");
        check("ror alucontrol", 8'(alucontrol), 8'b001);
        funct = 6'b101010;
        #1 check("rslt alucontrol", 8'(alucontrol), 8'b111);
        funct = 6'b111000;
        #1 check("rbad alucontrol", 8'(alucontrol), 8'b010);
        step();
        step();

        // lb
        op = 6'b100000;
        fetch_decode("lb");
        check("lb memadr state", 8'(state), 8'd5);
        check("lb memadr alusrcb", 8'(alusrcb), 8'd2);
        check("lb memadr alusrca", 8'(alusrca), 8'd1);
        step();
        check("lb rd state", 8'(state), 8'd6);
        check("lb rd iord", 8'(iord), 8'd1);
        check("lb rd memread", 8'(memread), 8'd1);
        step();
        check("lb wr state", 8'(state), 8'd7);
        check("lb wr regwrite", 8'(regwrite), 8'd1);
        check("lb wr memtoreg", 8'(memtoreg), 8'd1);
        check("lb wr regdst", 8'(regdst), 8'd0);
        step();
        check("lb done state", 8'(state), 8'd0);

        // sb
        op = 6'b101000;
        fetch_decode("sb");
        check("sb memadr state", 8'(state), 8'd5);
        step();
        check("sb wr state", 8'(state), 8'd8);
        check("sb wr memwrite", 8'(memwrite), 8'd1);
        check("sb wr iord", 8'(iord), 8'd1);
        check("sb wr regwrite", 8'(regwrite), 8'd0);
        step();
        check("sb done state", 8'(state), 8'd0);

        // beq taken then not taken
        op   = 6'b000100;
        zero = 1'b1;
        fetch_decode("beq1");
        check("beq1 state", 8'(state), 8'd11);
        check("beq1 pcen", 8'(pcen), 8'd1);
        check("beq1 pcsrc", 8'(pcsrc), 8'd1);
        check("beq1 alucontrol", 8'(alucontrol), 8'b110);
        step();
        check("beq1 done state", 8'(state), 8'd0);
        zero = 1'b0;
        fetch_decode("beq0");
        check("beq0 state", 8'(state), 8'd11);
        check("beq0 pcen", 8'(pcen), 8'd0);
        check("beq0 pcsrc", 8'(pcsrc), 8'd1);
        step();
        check("beq0 done state", 8'(state), 8'd0);

        // j
        op = 6'b000010;
        fetch_decode("j");
        check("j state", 8'(state), 8'd12);
        check("j pcen", 8'(pcen), 8'd1);
        check("j pcsrc", 8'(pcsrc), 8'd2);
        step();
        check("j done state", 8'(state), 8'd0);

        // addi
        op = 6'b001000;
        fetch_decode("addi");
        check("addi ex state", 8'(state), 8'd13);
        check("addi ex alusrcb", 8'(alusrcb), 8'd2);
        check("addi ex alucontrol", 8'(alucontrol), 8'b010);
        step();
        check("addi wr state", 8'(state), 8'd14);
        check("addi wr regwrite", 8'(regwrite), 8'd1);
        check("addi wr regdst", 8'(regdst), 8'd0);
        step();
        check("addi done state", 8'(state), 8'd0);

        // unknown op: NOP, back to fetch after decode
        op = 6'b111111;
        fetch_decode("nop");
        check("nop state", 8'(state), 8'd0);
        check("nop irwrite", 8'(irwrite), 8'd1);

        // reset during RTYPEEX aborts the write
        op    = 6'b000000;
        funct = 6'b100000;
        fetch_decode("abort");
        check("abort ex state", 8'(state), 8'd9);
        reset = 1'b1;
        #1;
        check("abort rst regwrite", 8'(regwrite), 8'd0);
        check("abort rst pcen", 8'(pcen), 8'd0);
        step();
        check("abort rst2 regwrite", 8'(regwrite), 8'd0);
        check("abort rst2 irwrite", 8'(irwrite), 8'd0);
        reset = 1'b0;
        #1;
        check("abort rel state", 8'(state), 8'd0);
        check("abort rel irwrite", 8'(irwrite), 8'd1);
        check("abort rel regwrite", 8'(regwrite), 8'd0);
        step();
        check("abort next state", 8'(state), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
